ssg_tone_bank: RTL and testbench

//  Parametrised successor to the 3-channel SSG tone/noise section: NUM_CH square-wave channels, shared 17-bit noise LFSR,
//  per-channel mixer and volume/envelope select, and a time-multiplexed log-DAC summer.

---
 rtl/ssg_pkg.sv | 44 ++++
 rtl/ssg_tone_bank_if.sv | 30 +++
 rtl/ssg_tone_channel.sv | 51 +++++
 rtl/ssg_tone_bank.sv | 195 +++++++++++++++++++
 tb/tb_ssg_tone_bank.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssg_pkg.sv
// SSG tone bank shared definitions.
// Log DAC table, register offsets, LFSR constants and summer states.
package ssg_pkg;

  // ~1.5 dB per step, index 15 is full scale
  localparam logic [15:0][7:0] DAC_LUT = {
    8'd255, 8'd215, 8'd181, 8'd152,
    8'd128, 8'd108, 8'd90,  8'd76,
    8'd64,  8'd54,  8'd45,  8'd38,
    8'd32,  8'd27,  8'd23,  8'd0
  };

  localparam logic [1:0] REG_PLO = 2'd0;
  localparam logic [1:0] REG_PHI = 2'd1;
  localparam logic [1:0] REG_VOL = 2'd2;
  localparam logic [1:0] REG_MIX = 2'd3;

  localparam logic [16:0] LFSR_SEED = 17'h00001;
  localparam int LFSR_TAP_A = 0;
  localparam int LFSR_TAP_B = 3;

  typedef enum logic [1:0] {
    SUM_IDLE,
    SUM_ACC,
    SUM_DONE
  } sum_state_e;

  typedef struct packed {
    logic       env_sel;
    logic [3:0] vol;
  } vol_reg_t;

  typedef struct packed {
    logic noise_dis;
    logic tone_dis;
  } mix_reg_t;

  function automatic logic [16:0] lfsr_next(
    input logic [16:0] s
  );
    return {s[LFSR_TAP_A] ^ s[LFSR_TAP_B], s[16:1]};
  endfunction

endpackage

// File: rtl/ssg_tone_bank_if.sv
// Register bus between the SSG decoder and the tone bank.
// Master drives strobes/address/data; slave returns read data.
interface ssg_tone_bank_if #(
  parameter int ADDR_W = 5
);
  logic              reg_wr;
  logic              reg_rd;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  logic              reg_rdata_en;

  modport master (
    output reg_wr,
    output reg_rd,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata,
    input  reg_rdata_en
  );

  modport slave (
    input  reg_wr,
    input  reg_rd,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata,
    output reg_rdata_en
  );
endinterface

// File: rtl/ssg_tone_channel.sv
// One square-wave tone channel.
// Holds the period register, tick counter and tone flip-flop.
module ssg_tone_channel
  import ssg_pkg::*;
#(
  parameter int PERIOD_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_i,
  input  logic                wr_lo_i,
  input  logic                wr_hi_i,
  input  logic [7:0]          wdata_i,
  output logic [PERIOD_W-1:0] period_o,
  output logic                tone_o
);

  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] limit;
  logic                tone_q;

  // period 0 behaves as 1; compare avoids wrap on shrink
  assign limit = (period_q == '0) ? '0
               : period_q - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      cnt_q    <= '0;
      tone_q   <= 1'b0;
    end else begin
      if (wr_lo_i)
        period_q[7:0] <= wdata_i;
      if (wr_hi_i)
        period_q[PERIOD_W-1:8] <= wdata_i[PERIOD_W-9:0];
      if (tick_i) begin
        if (cnt_q >= limit) begin
          cnt_q  <= '0;
          tone_q <= ~tone_q;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign period_o = period_q;
  assign tone_o   = tone_q;

endmodule

// File: rtl/ssg_tone_bank.sv
// NUM_CH-channel SSG tone/noise bank with mixer and
// time-multiplexed log-DAC summer.
module ssg_tone_bank
  import ssg_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int PERIOD_W = 12,
  parameter int PRESCALE = 96,
  parameter int ADDR_W   = 5,
  parameter int OUT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  ssg_tone_bank_if.slave   bus,
  input  logic [3:0]       env_level,
  output logic [OUT_W-1:0] sound_out
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [ADDR_W-1:0] NOISE_ADDR = ADDR_W'(4 * NUM_CH);

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic [4:0]       nper_q;
  logic [4:0]       ncnt_q;
  logic [4:0]       nlimit;
  logic             half_q;
  logic [16:0]      lfsr_q;
  logic             noise;

  vol_reg_t vol_q [NUM_CH];
  mix_reg_t mix_q [NUM_CH];

  logic [PERIOD_W-1:0] period_w [NUM_CH];
  logic                tone_w   [NUM_CH];
  logic [3:0]          level_w  [NUM_CH];

  logic [7:0] rdata_d;
  logic [7:0] rdata_q;
  logic       rdata_en_q;

  sum_state_e       state_q;
  logic [CH_W-1:0]  idx_q;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] sound_q;

  logic              in_ch;
  logic [ADDR_W-3:0] ch_sel;
  logic [1:0]        off;

  assign off    = bus.reg_addr[1:0];
  assign ch_sel = bus.reg_addr[ADDR_W-1:2];
  assign in_ch  = bus.reg_addr < NOISE_ADDR;

  assign tick  = enable && (pre_q == PRE_W'(PRESCALE - 1));
  assign noise = lfsr_q[0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    logic out;

    assign hit = bus.reg_wr && in_ch
              && (ch_sel == (ADDR_W-2)'(c));

    ssg_tone_channel #(
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (tick),
      .wr_lo_i  (hit && (off == REG_PLO)),
      .wr_hi_i  (hit && (off == REG_PHI)),
      .wdata_i  (bus.reg_wdata),
      .period_o (period_w[c]),
      .tone_o   (tone_w[c])
    );

    assign out = (tone_w[c] | mix_q[c].tone_dis)
               & (noise | mix_q[c].noise_dis);
    assign level_w[c] = !out ? 4'd0
                      : vol_q[c].env_sel ? env_level
                      : vol_q[c].vol;
  end

  always_comb begin
    rdata_d = 8'hFF;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_ch && (ch_sel == (ADDR_W-2)'(c))) begin
        unique case (off)
          REG_PLO: rdata_d = period_w[c][7:0];
          REG_PHI: rdata_d = 8'(period_w[c] >> 8);
          REG_VOL: rdata_d = {3'b0, vol_q[c]};
          REG_MIX: rdata_d = {6'b0, mix_q[c]};
          default: rdata_d = 8'hFF;
        endcase
      end
    end
    if (bus.reg_addr == NOISE_ADDR)
      rdata_d = {3'b0, nper_q};
  end

  // reads sample pre-write state when rd and wr collide
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        vol_q[c] <= '0;
        mix_q[c] <= '0;
      end
      nper_q     <= '0;
      rdata_q    <= '0;
      rdata_en_q <= 1'b0;
    end else begin
      rdata_en_q <= bus.reg_rd;
      if (bus.reg_rd)
        rdata_q <= rdata_d;
      if (bus.reg_wr) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (in_ch && (ch_sel == (ADDR_W-2)'(c))) begin
            if (off == REG_VOL)
              vol_q[c] <= vol_reg_t'(bus.reg_wdata[4:0]);
            if (off == REG_MIX)
              mix_q[c] <= mix_reg_t'(bus.reg_wdata[1:0]);
          end
        end
        if (bus.reg_addr == NOISE_ADDR)
          nper_q <= bus.reg_wdata[4:0];
      end
    end
  end

  assign nlimit = (nper_q == 5'd0) ? 5'd0
                : nper_q - 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      ncnt_q <= '0;
      half_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else begin
      if (enable)
        pre_q <= (pre_q == PRE_W'(PRESCALE - 1)) ? '0
               : pre_q + 1'b1;
      if (tick) begin
        if (ncnt_q >= nlimit) begin
          ncnt_q <= '0;
          half_q <= ~half_q;
          if (!half_q)
            lfsr_q <= lfsr_next(lfsr_q);
        end else begin
          ncnt_q <= ncnt_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SUM_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      sound_q <= '0;
    end else begin
      unique case (state_q)
        SUM_IDLE: begin
          if (tick) begin
            state_q <= SUM_ACC;
            idx_q   <= '0;
          end
        end
        SUM_ACC: begin
          acc_q <= acc_q
                 + OUT_W'(DAC_LUT[level_w[idx_q]]);
          if (idx_q == CH_W'(NUM_CH - 1))
            state_q <= SUM_DONE;
          else
            idx_q <= idx_q + 1'b1;
        end
        SUM_DONE: begin
          sound_q <= acc_q;
          acc_q   <= '0;
          state_q <= SUM_IDLE;
        end
        default: state_q <= SUM_IDLE;
      endcase
    end
  end

  assign bus.reg_rdata    = rdata_q;
  assign bus.reg_rdata_en = rdata_en_q;
  assign sound_out        = sound_q;

endmodule

// File: tb/tb_ssg_tone_bank.sv
// Directed bench for ssg_tone_bank.
// Read data and sound_out go through expectation queues.
module tb_ssg_tone_bank;

  localparam int NCH = 3;
  localparam int PRE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        en6 = 1'b0;
  logic [3:0]  env_level = 4'd0;
  logic [9:0]  sound_out;
  logic [10:0] sound6;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  rd_q [$];
  logic [9:0]  snd_q [$];
  logic [9:0]  last_snd = '0;
  logic [16:0] lfsr_m;
  logic        half_m;

  logic [7:0] lut [16] = '{
    8'd0,   8'd23,  8'd27,  8'd32,
    8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128,
    8'd152, 8'd181, 8'd215, 8'd255
  };

  ssg_tone_bank_if #(.ADDR_W(5)) bus ();
  ssg_tone_bank_if #(.ADDR_W(5)) bus6 ();

  ssg_tone_bank #(
    .NUM_CH(NCH), .PERIOD_W(12), .PRESCALE(PRE),
    .ADDR_W(5), .OUT_W(10)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .bus(bus), .env_level(env_level),
    .sound_out(sound_out)
  );

  ssg_tone_bank #(
    .NUM_CH(6), .PERIOD_W(12), .PRESCALE(PRE),
    .ADDR_W(5), .OUT_W(11)
  ) dut6 (
    .clk(clk), .reset(reset), .enable(en6),
    .bus(bus6), .env_level(env_level),
    .sound_out(sound6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.reg_rdata_en === 1'b1) begin
      if (rd_q.size() == 0)
        check("rd_extra_pulse",
              32'(bus.reg_rdata_en), 32'd0);
      else
        check("rd_data", 32'(bus.reg_rdata),
              32'(rd_q.pop_front()));
    end
  end

  task automatic wr(input logic [4:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    bus.reg_wr = 1'b1;
    bus.reg_addr = a;
    bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_wr = 1'b0;
  endtask

  task automatic wr6(input logic [4:0] a,
                     input logic [7:0] d);
    @(negedge clk);
    bus6.reg_wr = 1'b1;
    bus6.reg_addr = a;
    bus6.reg_wdata = d;
    @(negedge clk);
    bus6.reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a,
                    input logic [7:0] exp);
    @(negedge clk);
    bus.reg_rd = 1'b1;
    bus.reg_addr = a;
    rd_q.push_back(exp);
    @(negedge clk);
    bus.reg_rd = 1'b0;
  endtask

  task automatic rdwr(input logic [4:0] a,
                      input logic [7:0] d,
                      input logic [7:0] exp);
    @(negedge clk);
    bus.reg_rd = 1'b1;
    bus.reg_wr = 1'b1;
    bus.reg_addr = a;
    bus.reg_wdata = d;
    rd_q.push_back(exp);
    @(negedge clk);
    bus.reg_rd = 1'b0;
    bus.reg_wr = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) enable = 1'b1;
      @(negedge clk) enable = 1'b0;
    end
  endtask

  task automatic do_tick(input logic [9:0] exp);
    pulses(PRE);
    snd_q.push_back(exp);
    repeat (NCH) @(negedge clk);
    check("sound_hold", 32'(sound_out), 32'(last_snd));
    @(negedge clk);
    last_snd = snd_q.pop_front();
    check("sound", 32'(sound_out), 32'(last_snd));
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_snd = '0;
  endtask

  initial begin
    bus.reg_wr = 1'b0;  bus.reg_rd = 1'b0;
    bus.reg_addr = '0;  bus.reg_wdata = '0;
    bus6.reg_wr = 1'b0; bus6.reg_rd = 1'b0;
    bus6.reg_addr = '0; bus6.reg_wdata = '0;

    // reset and first read
    repeat (3) @(negedge clk);
    check("rst_sound", 32'(sound_out), 32'd0);
    check("rst_rden", 32'(bus.reg_rdata_en), 32'd0);
    check("rst_sound6", 32'(sound6), 32'd0);
    reset = 1'b0;
    rd(5'd0, 8'h00);
    @(negedge clk);
    check("rden_one_clk", 32'(bus.reg_rdata_en), 32'd0);
    rd(5'd2, 8'h00);
    rd(5'd12, 8'h00);

    // tone period 2, then period 0
    do_reset();
    wr(5'd0, 8'd2);
    wr(5'd2, 8'h0F);
    wr(5'd3, 8'h02);
    for (int n = 1; n <= 8; n++)
      do_tick(((n / 2) % 2) != 0 ? 10'd255 : 10'd0);
    do_reset();
    wr(5'd2, 8'h0F);
    wr(5'd3, 8'h02);
    for (int n = 1; n <= 4; n++)
      do_tick((n % 2) != 0 ? 10'd255 : 10'd0);

    // period shrink mid-count on ch1
    do_reset();
    wr(5'd6, 8'h0F);
    wr(5'd7, 8'h02);
    wr(5'd4, 8'h00);
    wr(5'd5, 8'h01);
    for (int n = 1; n <= 50; n++)
      do_tick(10'd0);
    wr(5'd4, 8'h03);
    wr(5'd5, 8'h00);
    for (int n = 1; n <= 7; n++)
      do_tick((((n - 1) / 3) % 2) == 0 ? 10'd255 : 10'd0);

    // noise LFSR against reference, 1000 shifts
    do_reset();
    wr(5'd2, 8'h0F);
    wr(5'd3, 8'h01);
    wr(5'd12, 8'h01);
    lfsr_m = 17'h00001;
    half_m = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      half_m = ~half_m;
      if (half_m)
        lfsr_m = {lfsr_m[0] ^ lfsr_m[3], lfsr_m[16:1]};
      do_tick(lfsr_m[0] ? 10'd255 : 10'd0);
    end

    // envelope select sweep on ch2
    do_reset();
    wr(5'd10, 8'h10);
    wr(5'd11, 8'h03);
    rd(5'd10, 8'h10);
    for (int e = 0; e < 16; e++) begin
      env_level = 4'(e);
      do_tick(10'(lut[e]));
    end
    env_level = 4'd0;

    // six-channel build at full volume
    do_reset();
    for (int c = 0; c < 6; c++) begin
      wr6(5'(4 * c + 2), 8'h0F);
      wr6(5'(4 * c + 3), 8'h03);
    end
    for (int i = 0; i < PRE; i++) begin
      @(negedge clk) en6 = 1'b1;
      @(negedge clk) en6 = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("ch6_hold", 32'(sound6), 32'd0);
    @(negedge clk);
    check("ch6_sum", 32'(sound6), 32'd1530);

    // register collisions and unmapped space
    do_reset();
    wr(5'd2, 8'h05);
    rdwr(5'd2, 8'h1A, 8'h05);
    rd(5'd2, 8'h1A);
    rd(5'd13, 8'hFF);
    rd(5'd31, 8'hFF);
    wr(5'd1, 8'hFF);
    rd(5'd1, 8'h0F);
    wr(5'd3, 8'hFF);
    rd(5'd3, 8'h03);
    wr(5'd12, 8'hFF);
    rd(5'd12, 8'h1F);
    wr(5'd14, 8'h55);
    rd(5'd14, 8'hFF);
    rd(5'd0, 8'h00);

    // reset while the summer is accumulating
    do_reset();
    wr(5'd2, 8'h0F);
    wr(5'd3, 8'h03);
    pulses(PRE);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_in_acc", 32'(sound_out), 32'd0);
    rd(5'd2, 8'h00);

    repeat (3) @(negedge clk);
    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check("snd_queue_empty", 32'(snd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
